// File: rtl/fifo_in_arbiter.sv
// rtl/fifo_in_arbiter.sv - round-robin burst arbiter feeding a single FIFO write port
// Grant is registered; ready/valid/data toward the FIFO are combinational off the grant.
module fifo_in_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int BURST   = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]         req_rdy_o,
    output logic                       fifo_valid_o,
    output logic [WIDTH-1:0]           fifo_data_o,
    input  logic                       fifo_rdy_i,
    output logic [NUM_REQ-1:0]         grant_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        g_q, g_d;
    logic [IW-1:0]        last_q, last_d;
    logic [CW-1:0]        burst_cnt_q, burst_cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;

    logic [IW-1:0]        base;
    logic [IW-1:0]        winner;
    logic                 found;
    logic                 any_valid;
    logic                 g_valid;
    logic                 xfer;
    logic                 release_now;

    assign any_valid   = |req_valid_i;
    assign g_valid     = req_valid_i[g_q];
    assign xfer        = (state_q == GRANT) && g_valid && fifo_rdy_i;
    assign release_now = (state_q == GRANT) &&
                         (!g_valid || (xfer && (burst_cnt_q == CW'(BURST - 1))));

    // While granted, the current holder becomes "last" on release, so search from it.
    assign base = (state_q == GRANT) ? g_q : last_q;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && req_valid_i[(int'(base) + i) % NUM_REQ]) begin
                winner = IW'((int'(base) + i) % NUM_REQ);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d     = GRANT;
                    g_d         = winner;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                if (release_now) begin
                    last_d      = g_q;
                    burst_cnt_d = '0;
                    if (any_valid) begin
                        g_d = winner;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
        endcase
        grant_d = (state_d == GRANT) ? (NUM_REQ'(1) << g_d) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            g_q         <= '0;
            last_q      <= IW'(NUM_REQ - 1);
            burst_cnt_q <= '0;
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            grant_q     <= grant_d;
        end
    end

    always_comb begin
        fifo_data_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q[k]) begin
                fifo_data_o = req_data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign req_rdy_o    = grant_q & {NUM_REQ{fifo_rdy_i}};
    assign fifo_valid_o = |(grant_q & req_valid_i);
    assign grant_o      = grant_q;

endmodule
